and_bist_ora: RTL and testbench
===============================

// Module: and_bist_ora
// PURPOSE
//  Output response analyzer and sequencer for the AND-gate BIST loop.
//  - Drives init/enable of the 2-bit pattern generator.
//  - Compresses the AND CUT response bits into a single-input signature register (SISR).
//  - After N_PATTERNS responses, compares the signature with GOLDEN and reports pass/fail.
//  - Sits between the TPG/CUT pair and the top-level BIST start/status interface.
// PARAMETERS
//  SIG_W       4       signature register width (>=2)
//  POLY        4'b0011 feedback tap mask, x^4+x+1 at default width
//  N_PATTERNS  4       responses compressed per run (>=1)
//  GOLDEN      4'h6    expected signature; default = seed 2'b00, fault-free AND
// PORTS
//  clk         in   1                   rising-edge clock
//  rst         in   1                   synchronous, active-high reset
//  start       in   1                   begin a run; sampled in IDLE and DONE only
//  resp_valid  in   1                   resp_in carries a CUT response this cycle
//  resp_in     in   1                   CUT (AND) output bit
//  tpg_init    out  1                   load seed into pattern generator
//  tpg_enable  out  1                   advance pattern generator
//  busy        out  1                   run in progress (LOAD or RUN or CHECK)
//  done        out  1                   run complete, result valid
//  pass        out  1                   signature == GOLDEN; valid while done=1
//  signature   out  SIG_W               current SISR contents
//  pat_count   out  $clog2(N_PATTERNS+1) responses accepted this run
// BEHAVIOUR
//  - All outputs are registered except tpg_init and tpg_enable, which decode the state.
//  - Reset, taking priority over everything:
//    - state=IDLE.
//    - signature=0, pat_count=0; busy, done, pass, tpg_init and tpg_enable all 0.
//  - FSM states: IDLE, LOAD, RUN, CHECK, DONE.
//  - IDLE:
//    - start=1 -> LOAD; otherwise stay.
//  - LOAD (exactly 1 cycle):
//    - tpg_init=1.
//    - signature<=0, pat_count<=0, done<=0, pass<=0.
//    - -> RUN.
//  - RUN:
//    - tpg_enable=1 every cycle.
//    - On resp_valid=1, compress resp_in:
//      - fb = signature[SIG_W-1] ^ resp_in
//      - signature <= {signature[SIG_W-2:0],1'b0} ^ (fb ? POLY : 0)
//      - pat_count <= pat_count+1
//    - resp_valid=0 -> signature and pat_count hold.
//    - The response that makes pat_count reach N_PATTERNS -> CHECK the next cycle.
//    - resp_valid in any state other than RUN is ignored.
//  - CHECK (1 cycle):
//    - pass <= (signature == GOLDEN), done <= 1, busy <= 0.
//    - -> DONE.
//  - DONE:
//    - done, pass and signature hold.
//    - start=1 -> LOAD; done and pass clear in LOAD.
//  - busy:
//    - Set on the cycle after start is accepted.
//    - Stays 1 through LOAD, RUN and CHECK; cleared as done is set.
//  - Latency: start to done = N_PATTERNS + 3 cycles when resp_valid=1 on every RUN cycle.
//  - start during LOAD, RUN or CHECK is ignored; no restart and no error.
//  - A run always ends after exactly N_PATTERNS accepted responses.
//  - pat_count wraps only through LOAD; it never exceeds N_PATTERNS.
//  - rst mid-run aborts immediately to the reset state; no partial result is reported.
// TESTING
//  - Reset values: assert rst for 2 cycles with random inputs -> all outputs 0, state IDLE.
//  - Golden run, fault-free:
//    - Stimulus: start pulse; resp 0,0,1,0 with resp_valid=1.
//    - Expected: signature steps 0,0,3,6; done=1 with pass=1 at cycle 7; tpg_init high only in cycle 2.
//  - Stuck-at-0 CUT: resp 0,0,0,0 -> signature 0, done=1, pass=0.
//  - Gapped valid:
//    - Stimulus: resp_valid pattern 1,0,0,1,1,0,1 with bits 0,x,x,0,1,x,0.
//    - Expected: signature 6, pass=1, pat_count=4; holds on the invalid cycles.
//  - Start handling: start pulsed mid-RUN -> ignored, run completes normally; start in DONE -> LOAD, done/pass clear the next cycle.
//  - Reset mid-run: rst after 2 responses -> next cycle signature=0, pat_count=0, busy=0, state IDLE.

Source files
------------

// File: rtl/and_bist_ora.sv
// ----------------------------------------------------------------------------
// and_bist_ora
//   Output response analyzer and sequencer for the AND-gate BIST loop.
//   Drives the pattern generator (seed load / advance), folds each CUT
//   response bit into a single-input signature register, and after
//   N_PATTERNS accepted responses compares the signature against GOLDEN.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   start       in   begin a run (honoured in IDLE and DONE only)
//   resp_valid  in   resp_in carries a CUT response this cycle
//   resp_in     in   CUT (AND) output bit
//   tpg_init    out  load seed into pattern generator (decoded from state)
//   tpg_enable  out  advance pattern generator (decoded from state)
//   busy        out  run in progress (LOAD, RUN, CHECK)
//   done        out  run complete, pass/signature valid
//   pass        out  signature matched GOLDEN; valid while done=1
//   signature   out  current SISR contents
//   pat_count   out  responses accepted in this run
// ----------------------------------------------------------------------------
module and_bist_ora #(
    parameter int               SIG_W      = 4,
    parameter logic [SIG_W-1:0] POLY       = 'b0011,
    parameter int               N_PATTERNS = 4,
    parameter logic [SIG_W-1:0] GOLDEN     = 'h6,
    localparam int              CNT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic             resp_in,
    output logic             tpg_init,
    output logic             tpg_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pat_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [SIG_W-1:0]   r_sig;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_last;

    // One SISR step: shift left, feedback is MSB xor the incoming bit.
    function automatic logic [SIG_W-1:0] sisr_step(input logic [SIG_W-1:0] sig,
                                                   input logic             bit_in);
        logic fb;
        fb = sig[SIG_W-1] ^ bit_in;
        return {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    // A response is only consumed while running.
    assign w_accept = (r_state == S_RUN) && resp_valid;
    // The accepted response that brings the count to N_PATTERNS ends the run.
    assign w_last   = w_accept && (r_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_CHECK;
            S_CHECK: w_next = S_DONE;
            S_DONE:  if (start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Decoded pattern-generator controls
    always_comb begin
        tpg_init   = (r_state == S_LOAD);
        tpg_enable = (r_state == S_RUN);
    end

    // Registered status, signature and count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_sig  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Accepting a new run drops the previous result at once so
                    // busy and done are never seen together.
                    if (start) begin
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_sig  <= '0;
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                    r_pass <= 1'b0;
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_sig <= sisr_step(r_sig, resp_in);
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_pass <= (r_sig == GOLDEN);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;
    assign pat_count = r_cnt;

endmodule

// File: tb/tb_and_bist_ora.sv
module tb_and_bist_ora;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       resp_valid;
    logic       resp_in;
    logic       tpg_init;
    logic       tpg_enable;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;
    logic [2:0] pat_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] sig;
        logic       pass;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic done_q = 1'b0;

    and_bist_ora dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .resp_valid (resp_valid),
        .resp_in    (resp_in),
        .tpg_init   (tpg_init),
        .tpg_enable (tpg_enable),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pat_count  (pat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every rising edge of done is one completed run; compare it
    // with the oldest expected result.
    always @(negedge clk) begin
        if (rst) begin
            done_q = 1'b0;
        end else begin
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_sig"},  32'(signature), 32'(e.sig));
                    chk({e.name, "_pass"}, 32'(pass),      32'(e.pass));
                    chk({e.name, "_cnt"},  32'(pat_count), 32'(e.cnt));
                end
            end
            done_q = done;
        end
    end

    // One complete run. vv/bb give resp_valid/resp_in per RUN cycle; trace
    // holds the expected signature (one nibble per cycle) after each cycle.
    // mid >= 0 pulses start on that RUN cycle.
    task automatic run(input string nm, input int n, input logic [15:0] vv,
                       input logic [15:0] bb, input logic [63:0] trace,
                       input logic [3:0] esig, input logic epass, input int mid);
        exp_t e;
        e.name = nm; e.sig = esig; e.pass = epass; e.cnt = 3'd4;
        exp_q.push_back(e);
        start = 1'b1; resp_valid = 1'b0; resp_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        // LOAD cycle
        chk({nm, "_load_init"}, 32'(tpg_init),   1);
        chk({nm, "_load_en"},   32'(tpg_enable), 0);
        chk({nm, "_load_busy"}, 32'(busy),       1);
        chk({nm, "_load_done"}, 32'(done),       0);
        @(posedge clk); #1;
        // RUN cycles
        chk({nm, "_run_en"},   32'(tpg_enable), 1);
        chk({nm, "_run_init"}, 32'(tpg_init),   0);
        chk({nm, "_run_pass"}, 32'(pass),       0);
        for (int i = 0; i < n; i++) begin
            resp_valid = vv[i];
            resp_in    = vv[i] ? bb[i] : 1'($urandom);
            start      = (i == mid);
            @(posedge clk); #1;
            chk($sformatf("%s_sig%0d", nm, i), 32'(signature), 32'(trace[4*i +: 4]));
        end
        start = 1'b0; resp_valid = 1'b0;
        // CHECK cycle
        chk({nm, "_chk_busy"}, 32'(busy),       1);
        chk({nm, "_chk_done"}, 32'(done),       0);
        chk({nm, "_chk_en"},   32'(tpg_enable), 0);
        @(posedge clk); #1;
        // DONE: result must hold and responses must be ignored
        chk({nm, "_done_busy"}, 32'(busy), 0);
        resp_valid = 1'b1; resp_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_hold_done"}, 32'(done),      1);
        chk({nm, "_hold_pass"}, 32'(pass),      32'(epass));
        chk({nm, "_hold_sig"},  32'(signature), 32'(esig));
        resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'($urandom); resp_valid = 1'($urandom); resp_in = 1'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            start = 1'($urandom); resp_valid = 1'($urandom); resp_in = 1'($urandom);
        end
        chk("rst_sig",  32'(signature),  0);
        chk("rst_cnt",  32'(pat_count),  0);
        chk("rst_busy", 32'(busy),       0);
        chk("rst_done", 32'(done),       0);
        chk("rst_pass", 32'(pass),       0);
        chk("rst_init", 32'(tpg_init),   0);
        chk("rst_en",   32'(tpg_enable), 0);
        rst = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_in = 1'b0;
        @(posedge clk); #1;
        chk("idle_init", 32'(tpg_init), 0);
        chk("idle_busy", 32'(busy),     0);

        // Fault-free golden run: 0,0,1,0 -> 0,0,3,6
        run("golden", 4, 16'h000F, 16'h0004, 64'h6300, 4'h6, 1'b1, -1);
        // Stuck-at-0 CUT, started from DONE
        run("sa0", 4, 16'h000F, 16'h0000, 64'h0000, 4'h0, 1'b0, -1);
        // Gapped valid 1,0,0,1,1,0,1 with bits 0,x,x,0,1,x,0
        run("gap", 7, 16'h0059, 16'h0010, 64'h6330000, 4'h6, 1'b1, -1);
        // start pulsed mid-RUN is ignored
        run("midstart", 4, 16'h000F, 16'h0004, 64'h6300, 4'h6, 1'b1, 1);

        // Reset mid-run after two responses (0,1 -> signature 3)
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        resp_valid = 1'b1; resp_in = 1'b0;
        @(posedge clk); #1;
        resp_in = 1'b1;
        @(posedge clk); #1;
        chk("abort_pre_sig", 32'(signature), 3);
        chk("abort_pre_cnt", 32'(pat_count), 2);
        rst = 1'b1; resp_valid = 1'b1; resp_in = 1'b1;
        @(posedge clk); #1;
        chk("abort_sig",  32'(signature),  0);
        chk("abort_cnt",  32'(pat_count),  0);
        chk("abort_busy", 32'(busy),       0);
        chk("abort_done", 32'(done),       0);
        chk("abort_en",   32'(tpg_enable), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        // Back in IDLE: responses ignored, nothing running
        chk("abort_idle_init", 32'(tpg_init),   0);
        chk("abort_idle_en",   32'(tpg_enable), 0);
        chk("abort_idle_sig",  32'(signature),  0);
        chk("abort_idle_busy", 32'(busy),       0);
        resp_valid = 1'b0;

        // Fresh run after the abort still works
        run("after_abort", 4, 16'h000F, 16'h0004, 64'h6300, 4'h6, 1'b1, -1);

        begin
            int budget;
            budget = 50;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() != 0) chk("pending_results", exp_q.size(), 0);
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
